// File: rtl/line_write_scheduler_pkg.sv
// rtl/line_write_scheduler_pkg.sv - shared widths, FSM states and step helper for the line write scheduler
package line_write_scheduler_pkg;

  localparam int X_MAC        = 4;
  localparam int ADDR_LEN     = 13;
  localparam int MAX_LINE_LEN = 10;
  localparam int LINE_CNT_W   = 10;
  localparam int ADDR_W       = ADDR_LEN * X_MAC;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_REQ,
    S_WAIT_IDLE,
    S_NEXT,
    S_FINISH
  } state_e;

  // Buffer words one line occupies: 4 pixels/word pooled, 2 pixels/word in 2x2 packing.
  function automatic logic [ADDR_LEN-1:0] words_per_line(input logic [MAX_LINE_LEN-1:0] linelen,
                                                         input logic                    pooled);
    logic [MAX_LINE_LEN:0] ext;
    ext = {1'b0, linelen} + {{(MAX_LINE_LEN-1){1'b0}}, pooled, 1'b1};
    return ADDR_LEN'(pooled ? (ext >> 2) : (ext >> 1));
  endfunction

endpackage

// File: rtl/line_write_scheduler_addr_gen.sv
// rtl/line_write_scheduler_addr_gen.sv - per-MAC line start addresses with load and wrapping step
module line_addr_gen
  import line_write_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic                step_en_i,
  input  logic [ADDR_W-1:0]   base_i,
  input  logic [ADDR_LEN-1:0] step_i,
  output logic [ADDR_W-1:0]   addr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;

  // Each field wraps on its own; no carry crosses into the neighbouring bank.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = base_i;
    end else if (step_en_i) begin
      for (int f = 0; f < X_MAC; f++) begin
        addr_d[f*ADDR_LEN +: ADDR_LEN] = addr_q[f*ADDR_LEN +: ADDR_LEN] + step_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/line_write_scheduler.sv
// rtl/line_write_scheduler.sv - drives the line write controller once per output line of a tile
module line_write_scheduler
  import line_write_scheduler_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W-1:0]       cfg_base_addr,
  input  logic [MAX_LINE_LEN-1:0] cfg_linelen,
  input  logic [LINE_CNT_W-1:0]   cfg_line_num,
  input  logic [ADDR_LEN-1:0]     cfg_stride,
  input  logic                    cfg_pooled,
  input  logic [1:0]              cfg_valid_mac,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [LINE_CNT_W-1:0]   line_idx,
  output logic                    wc_conf_input,
  output logic [ADDR_W-1:0]       wc_st_addr,
  output logic [MAX_LINE_LEN-1:0] wc_linelen,
  output logic                    wc_pooled,
  output logic [1:0]              wc_valid_mac,
  input  logic                    wc_req,
  input  logic                    wc_idle
);

  state_e                  state_q;
  logic                    done_q;
  logic [LINE_CNT_W-1:0]   line_idx_q;
  logic [LINE_CNT_W-1:0]   line_num_q;
  logic [ADDR_LEN-1:0]     step_q;
  logic [MAX_LINE_LEN-1:0] linelen_q;
  logic                    pooled_q;
  logic [1:0]              valid_mac_q;
  logic                    accept;
  logic                    last_line;
  logic                    advance;

  assign ready     = (state_q == S_IDLE) & wc_idle;
  assign accept    = start & ready & ~abort;
  assign last_line = (line_idx_q == line_num_q - LINE_CNT_W'(1));
  assign advance   = (state_q == S_NEXT) & ~last_line & ~abort;

  line_addr_gen u_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (accept),
    .step_en_i (advance),
    .base_i    (cfg_base_addr),
    .step_i    (step_q),
    .addr_o    (wc_st_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      line_idx_q  <= '0;
      line_num_q  <= '0;
      step_q      <= '0;
      linelen_q   <= '0;
      pooled_q    <= 1'b0;
      valid_mac_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              linelen_q   <= cfg_linelen;
              pooled_q    <= cfg_pooled;
              valid_mac_q <= cfg_valid_mac;
              line_num_q  <= cfg_line_num;
              step_q      <= (cfg_stride != '0) ? cfg_stride
                                                : words_per_line(cfg_linelen, cfg_pooled);
              line_idx_q  <= '0;
              state_q     <= (cfg_line_num == '0) ? S_FINISH : S_ISSUE;
            end
          end
          S_ISSUE:     state_q <= S_WAIT_REQ;
          // The controller only raises req after its own delayed conf, so this wait is unbounded.
          S_WAIT_REQ:  if (wc_req)  state_q <= S_WAIT_IDLE;
          S_WAIT_IDLE: if (wc_idle) state_q <= S_NEXT;
          S_NEXT: begin
            if (last_line) begin
              state_q <= S_FINISH;
            end else begin
              line_idx_q <= line_idx_q + LINE_CNT_W'(1);
              state_q    <= S_ISSUE;
            end
          end
          S_FINISH: begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign line_idx      = line_idx_q;
  assign wc_conf_input = (state_q == S_ISSUE) & ~abort;
  assign wc_linelen    = linelen_q;
  assign wc_pooled     = pooled_q;
  assign wc_valid_mac  = valid_mac_q;

endmodule

// File: tb/tb_line_write_scheduler.sv
// tb/tb_line_write_scheduler.sv - randomized self-checking bench for line_write_scheduler
module tb_line_write_scheduler;
  import line_write_scheduler_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    abort = 1'b0;
  logic [ADDR_W-1:0]       cfg_base_addr = '0;
  logic [MAX_LINE_LEN-1:0] cfg_linelen = '0;
  logic [LINE_CNT_W-1:0]   cfg_line_num = '0;
  logic [ADDR_LEN-1:0]     cfg_stride = '0;
  logic                    cfg_pooled = 1'b0;
  logic [1:0]              cfg_valid_mac = '0;
  logic                    ready, busy, done, wc_conf_input, wc_pooled;
  logic [LINE_CNT_W-1:0]   line_idx;
  logic [ADDR_W-1:0]       wc_st_addr;
  logic [MAX_LINE_LEN-1:0] wc_linelen;
  logic [1:0]              wc_valid_mac;
  logic                    wc_req, wc_idle;

  always #5 clk = ~clk;

  line_write_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_linelen(cfg_linelen), .cfg_line_num(cfg_line_num),
    .cfg_stride(cfg_stride), .cfg_pooled(cfg_pooled), .cfg_valid_mac(cfg_valid_mac),
    .ready(ready), .busy(busy), .done(done), .line_idx(line_idx),
    .wc_conf_input(wc_conf_input), .wc_st_addr(wc_st_addr), .wc_linelen(wc_linelen),
    .wc_pooled(wc_pooled), .wc_valid_mac(wc_valid_mac), .wc_req(wc_req), .wc_idle(wc_idle)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0]       addr;
    logic [MAX_LINE_LEN-1:0] len;
    logic                    pool;
    logic [1:0]              vm;
    logic [LINE_CNT_W-1:0]   idx;
  } cap_t;

  cap_t cap_q[$];
  int   done_cnt = 0;

  always @(negedge clk) begin
    if (wc_conf_input) cap_q.push_back('{wc_st_addr, wc_linelen, wc_pooled, wc_valid_mac, line_idx});
    if (done) done_cnt++;
  end

  // Write controller stand-in: req after a delay, busy for a while, optionally held busy.
  bit respond = 1'b1;
  int hold_at = -1;
  int dc_seen = 0;

  initial begin
    wc_req  = 1'b0;
    wc_idle = 1'b1;
    forever begin
      @(negedge clk);
      if (respond && wc_conf_input) begin
        dc_seen++;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        wc_req  = 1'b1;
        wc_idle = 1'b0;
        @(negedge clk);
        wc_req = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        while (dc_seen == hold_at) @(negedge clk);
        wc_idle = 1'b1;
      end
    end
  end

  function automatic logic [ADDR_W-1:0] rand_base();
    return {20'($urandom), $urandom};
  endfunction

  function automatic int step_of(input int len, input int pool, input int stride);
    if (stride != 0) return stride;
    return (pool != 0) ? (len + 3) / 4 : (len + 1) / 2;
  endfunction

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] base, input int step, input int k);
    logic [ADDR_W-1:0] r;
    int v;
    r = '0;
    for (int f = 0; f < X_MAC; f++) begin
      v = (int'(base[f*ADDR_LEN +: ADDR_LEN]) + k * step) % (1 << ADDR_LEN);
      r[f*ADDR_LEN +: ADDR_LEN] = ADDR_LEN'(v);
    end
    return r;
  endfunction

  task automatic set_cfg(input logic [ADDR_W-1:0] base, input int len, input int pool,
                         input int nl, input int stride, input int vm);
    cfg_base_addr = base;
    cfg_linelen   = MAX_LINE_LEN'(len);
    cfg_pooled    = (pool != 0);
    cfg_line_num  = LINE_CNT_W'(nl);
    cfg_stride    = ADDR_LEN'(stride);
    cfg_valid_mac = 2'(vm);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk(tag, 64'(0), 64'(1));
  endtask

  task automatic run_tile(input string tag, input logic [ADDR_W-1:0] base, input int len,
                          input int pool, input int nl, input int stride, input int vm, input int budget);
    int cb, d0, st, cyc;
    cap_t c;
    wait_ready({tag, "_ready"});
    cb = cap_q.size();
    d0 = done_cnt;
    set_cfg(base, len, pool, nl, stride, vm);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done_cnt == d0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'(1));
    chk({tag, "_conf_cnt"}, 64'(cap_q.size() - cb), 64'(nl));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    st = step_of(len, pool, stride);
    for (int k = 0; k < nl && cb + k < cap_q.size(); k++) begin
      c = cap_q[cb + k];
      chk($sformatf("%s_addr%0d", tag, k), 64'(c.addr), 64'(exp_addr(base, st, k)));
      chk($sformatf("%s_idx%0d", tag, k), 64'(c.idx), 64'(k));
      chk($sformatf("%s_len%0d", tag, k), 64'(c.len), 64'(len));
      chk($sformatf("%s_pool%0d", tag, k), 64'(c.pool), 64'(pool != 0));
      chk($sformatf("%s_vm%0d", tag, k), 64'(c.vm), 64'(vm));
    end
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [ADDR_W-1:0] b;
    int cb, d0, n;

    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_conf", 64'(wc_conf_input), 64'(0));
    chk("rst_idx", 64'(line_idx), 64'(0));
    chk("rst_addr", 64'(wc_st_addr), 64'(0));
    chk("rst_len", 64'(wc_linelen), 64'(0));
    chk("rst_pool", 64'(wc_pooled), 64'(0));
    chk("rst_vm", 64'(wc_valid_mac), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'(1));

    run_tile("t_pool8", {13'd300, 13'd200, 13'd100, 13'd0}, 8, 1, 3, 0, 2, 500);
    run_tile("t_unp7", rand_base(), 7, 0, 2, 0, 1, 500);
    b = rand_base();
    b[ADDR_LEN-1:0] = 13'd8190;
    run_tile("t_wrap", b, 20, 1, 2, 5, 3, 500);

    // Zero-line tile: straight to FINISH, done two edges after start.
    wait_ready("z_ready");
    cb = cap_q.size();
    set_cfg(rand_base(), 12, 0, 0, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("z_busy1", 64'(busy), 64'(1));
    chk("z_done1", 64'(done), 64'(0));
    @(negedge clk);
    chk("z_busy2", 64'(busy), 64'(0));
    chk("z_done2", 64'(done), 64'(1));
    @(negedge clk);
    chk("z_done3", 64'(done), 64'(0));
    chk("z_conf", 64'(cap_q.size() - cb), 64'(0));

    // start together with abort in IDLE is dropped.
    set_cfg(rand_base(), 4, 1, 2, 0, 0);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
    chk("sa_conf", 64'(cap_q.size() - cb), 64'(0));

    // Abort while the second of four lines is still draining.
    wait_ready("ab_ready");
    cb = cap_q.size();
    d0 = done_cnt;
    hold_at = dc_seen + 2;
    set_cfg(rand_base(), 16, 0, 4, 0, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (dc_seen != hold_at && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ab_reach", 64'(dc_seen == hold_at), 64'(1));
    repeat (8) @(negedge clk);
    chk("ab_busy_pre", 64'(busy), 64'(1));
    chk("ab_idx_pre", 64'(line_idx), 64'(1));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 64'(busy), 64'(0));
    chk("ab_ready0", 64'(ready), 64'(0));
    set_cfg(rand_base(), 4, 1, 1, 0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("ab_conf", 64'(cap_q.size() - cb), 64'(2));
    chk("ab_busy2", 64'(busy), 64'(0));
    hold_at = -1;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ab_ready1", 64'(ready), 64'(1));
    chk("ab_done", 64'(done_cnt - d0), 64'(0));
    if (cap_q.size() >= cb + 2) chk("ab_idx1", 64'(cap_q[cb + 1].idx), 64'(1));

    // Asynchronous reset while waiting for req.
    respond = 1'b0;
    cb = cap_q.size();
    set_cfg(rand_base(), 30, 1, 3, 0, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (cap_q.size() == cb && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    chk("ar_busy_pre", 64'(busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 64'(busy), 64'(0));
    chk("ar_addr", 64'(wc_st_addr), 64'(0));
    chk("ar_len", 64'(wc_linelen), 64'(0));
    chk("ar_pool", 64'(wc_pooled), 64'(0));
    chk("ar_vm", 64'(wc_valid_mac), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    respond = 1'b1;
    run_tile("t_after_rst", rand_base(), 9, 0, 1, 0, 3, 500);

    for (int t = 0; t < 10; t++) begin
      run_tile($sformatf("rnd%0d", t), rand_base(), int'($urandom_range(0, 1023)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 6)),
               ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 8191)) : 0,
               int'($urandom_range(0, 3)), 1000);
    end

    run_tile("t_max", rand_base(), int'($urandom_range(1, 1023)), int'($urandom_range(0, 1)),
             (1 << LINE_CNT_W) - 1, 0, int'($urandom_range(0, 3)), 20000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
